srl_arbiter: RTL and testbench
==============================

// Module: srl_arbiter
// PURPOSE
//   Shares one combinational srl (logical right shift, result = a >> b) between two requesters.
//   Each requester presents operands with a valid/ready handshake.
//   The block arbitrates, registers the operands, drives the shared srl and holds the result in a one-entry response buffer.
//   The response is tagged with the requester id and sits between the ALU issue logic and the shared shift datapath.
// PARAMETERS
//   WIDTH       32  operand/result width; must equal the srl datapath width (32)
//   PRIO_FIXED  0   0 = round-robin between req0/req1; 1 = req0 always wins ties
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   req0_valid   in   1      requester 0 has operands
//   req0_ready   out  1      requester 0 operands accepted this cycle
//   req0_a       in   WIDTH  requester 0 value to shift
//   req0_b       in   WIDTH  requester 0 shift amount
//   req1_valid   in   1      requester 1 has operands
//   req1_ready   out  1      requester 1 operands accepted this cycle
//   req1_a       in   WIDTH  requester 1 value to shift
//   req1_b       in   WIDTH  requester 1 shift amount
//   resp_valid   out  1      resp_id/resp_result valid
//   resp_ready   in   1      consumer takes the response
//   resp_id      out  1      0 = result belongs to req0, 1 = req1
//   resp_result  out  WIDTH  srl(a, b) of the granted request
// BEHAVIOUR
//   - FSM states: IDLE -> EXEC -> RESP -> IDLE. One operation in flight.
//   - IDLE:
//     - Grant is decided combinationally and the winner's reqN_ready is driven high.
//     - A handshake (valid & ready) captures a, b and id into registers; next state EXEC.
//     - With no valid request, stay in IDLE.
//   - EXEC: the srl is fed from the registered a/b; its result is registered into resp_result. Next state RESP.
//   - RESP:
//     - resp_valid = 1.
//     - resp_result and resp_id are held stable until resp_valid & resp_ready.
//     - On that handshake, go to IDLE.
//   - reqN_ready is 0 in EXEC and RESP. No new grant is issued in the same cycle a response drains.
//   - Latency: accept edge at cycle 0 -> resp_valid high from cycle 2. Back-to-back throughput is 1 op per 3 cycles (with resp_ready held high).
//   - Arbitration:
//     - Only one request valid: it wins.
//     - Both valid with PRIO_FIXED=0: grant goes to the requester not served last. The last_id register updates on each accept and resets to 1, so req0 wins the first tie.
//     - Both valid with PRIO_FIXED=1: req0 wins.
//   - Arithmetic: a and b are passed unmodified to the srl. The result is whatever srl defines; the arbiter adds no masking.
//   - A requester may drop valid before being granted. Nothing is captured.
//   - Reset (asynchronous, any state, including mid-EXEC/RESP):
//     - State goes to IDLE, resp_valid=0, resp_result=0, resp_id=0, last_id=1; reqN_ready=0 while rst_n=0.
//     - The in-flight operation is discarded; no response appears after reset release.
// CONFIGURATION
//   SRL_ARB_BYPASS_EN defined:
//     - The EXEC state is removed. The srl is fed directly from the winner's input operands and its result is registered on the accept edge.
//     - Flow is IDLE -> RESP; resp_valid is high from cycle 1. Throughput is 1 op per 2 cycles.
//   SRL_ARB_BYPASS_EN undefined: the 3-state flow above (operand register, latency 2).
//   Port list and arbitration are identical in both builds.
// TESTING
//   1. req0 only, a=80000000 b=1, resp_ready=1:
//      - req0_ready=1 at cycle 0.
//      - resp_valid at cycle 2 (cycle 1 with BYPASS), resp_id=0, resp_result=40000000.
//   2. req1 only, a=08DF0000 b=5: resp_id=1, resp_result=0046F800; resp_valid low the cycle after the handshake.
//   3. Both valid continuously with PRIO_FIXED=0 (a0=80000000 b0=1F, a1=40000000 b1=2):
//      - Grants alternate 0,1,0,1.
//      - Results alternate 00000001 and 10000000.
//   4. Back-pressure: hold resp_ready=0 for 5 cycles in RESP.
//      - resp_result/resp_id stay stable and both reqN_ready stay 0.
//      - Raising resp_ready drains the response, then IDLE accepts the next request.
//   5. PRIO_FIXED=1, both valid for 3 operations: all three grants go to req0 (resp_id=0); req1_ready stays 0.
//   6. Assert rst_n=0 asynchronously during EXEC and again during RESP:
//      - resp_valid drops immediately, outputs go to 0.
//      - After release, the first tie is granted to req0 and no stale response is seen.

Source files
------------

// File: rtl/srl_arbiter.sv
// Two-requester arbiter in front of one shared logical-right-shift unit, with a one-entry tagged response buffer.
// Optional build macro: SRL_ARB_BYPASS_EN feeds the shifter straight from the winner and skips the EXEC state.
module srl_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          PRIO_FIXED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             grant_id_c;
  logic             accept_c;
  logic             last_id_q;
  logic [WIDTH-1:0] srl_a_c;
  logic [WIDTH-1:0] srl_b_c;
  logic [WIDTH-1:0] srl_res_c;
`ifndef SRL_ARB_BYPASS_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, grant and ready; ready is held low while reset is asserted
  always_comb begin
    state_nxt  = state;
    grant_id_c = 1'b0;
    accept_c   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant_id_c = PRIO_FIXED ? 1'b0 : ~last_id_q;
        end else begin
          grant_id_c = req1_valid;
        end
        if (rst_n && (req0_valid || req1_valid)) begin
          accept_c   = 1'b1;
          req0_ready = ~grant_id_c;
          req1_ready = grant_id_c;
`ifdef SRL_ARB_BYPASS_EN
          state_nxt  = RESP;
`else
          state_nxt  = EXEC;
`endif
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared shifter operand selection
  always_comb begin
`ifdef SRL_ARB_BYPASS_EN
    srl_a_c = grant_id_c ? req1_a : req0_a;
    srl_b_c = grant_id_c ? req1_b : req0_b;
`else
    srl_a_c = a_q;
    srl_b_c = b_q;
`endif
    srl_res_c = srl_a_c >> srl_b_c;
  end

  // Operand capture, response buffer and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id_q   <= 1'b1;
      resp_id     <= 1'b0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
`ifndef SRL_ARB_BYPASS_EN
      a_q         <= '0;
      b_q         <= '0;
`endif
    end else begin
      resp_valid <= (state_nxt == RESP);
      if (accept_c) begin
        last_id_q <= grant_id_c;
        resp_id   <= grant_id_c;
`ifdef SRL_ARB_BYPASS_EN
        resp_result <= srl_res_c;
`else
        a_q <= grant_id_c ? req1_a : req0_a;
        b_q <= grant_id_c ? req1_b : req0_b;
`endif
      end
`ifndef SRL_ARB_BYPASS_EN
      if (state == EXEC) begin
        resp_result <= srl_res_c;
      end
`endif
    end
  end

endmodule

// File: tb/tb_srl_arbiter.sv
// Directed bench for srl_arbiter: one round-robin instance and one fixed-priority instance on shared stimulus.
module tb_srl_arbiter;
  localparam int unsigned W = 32;
`ifdef SRL_ARB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req1_valid = 1'b0;
  logic         resp_ready = 1'b0;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;

  logic         rr_req0_ready, rr_req1_ready, rr_resp_valid, rr_resp_id;
  logic [W-1:0] rr_resp_result;
  logic         fx_req0_ready, fx_req1_ready, fx_resp_valid, fx_resp_id;
  logic [W-1:0] fx_resp_result;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  srl_arbiter #(.WIDTH(W), .PRIO_FIXED(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(rr_resp_valid), .resp_ready(resp_ready), .resp_id(rr_resp_id),
    .resp_result(rr_resp_result)
  );

  srl_arbiter #(.WIDTH(W), .PRIO_FIXED(1'b1)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fx_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(fx_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(fx_resp_valid), .resp_ready(resp_ready), .resp_id(fx_resp_id),
    .resp_result(fx_resp_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One request on the round-robin instance, drained immediately
  task automatic single_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string tag);
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    resp_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(id ? rr_req1_ready : rr_req0_ready), 32'd1);
    check({tag, "_nrdy"}, 32'(id ? rr_req0_ready : rr_req1_ready), 32'd0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      check({tag, "_lat"}, 32'(rr_resp_valid), 32'(k == LAT));
    end
    check({tag, "_id"}, 32'(rr_resp_id), 32'(id));
    check({tag, "_res"}, rr_resp_result, exp);
    @(negedge clk);
    #1;
    check({tag, "_drain"}, 32'(rr_resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int got;
    // Reset state, ready gated while in reset
    req0_valid = 1'b1;
    #12;
    check("rst_valid", 32'(rr_resp_valid), 32'd0);
    check("rst_result", rr_resp_result, 32'd0);
    check("rst_id", 32'(rr_resp_id), 32'd0);
    check("rst_ready", 32'(rr_req0_ready), 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    single_op(1'b0, 32'h8000_0000, 32'd1, 32'h4000_0000, "t1");
    single_op(1'b1, 32'h08DF_0000, 32'd5, 32'h0046_F800, "t2");

    // Round robin with both valid continuously; last grant was req1
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h8000_0000; req0_b = 32'h1F;
    req1_valid = 1'b1; req1_a = 32'h4000_0000; req1_b = 32'd2;
    resp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      #1;
      if (rr_resp_valid) begin
        check("rr_id", 32'(rr_resp_id), 32'(got % 2));
        check("rr_res", rr_resp_result, (got % 2 == 1) ? 32'h1000_0000 : 32'h0000_0001);
        got++;
      end
      @(negedge clk);
      if (got == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    check("rr_count", 32'(got), 32'd4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Back-pressure: response held for 5 cycles while inputs keep changing
    @(negedge clk);
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'hF0F0_F0F0; req0_b = 32'd4;
    #1;
    check("bp_rdy", 32'(rr_req0_ready), 32'd1);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req0_a = 32'hFFFF_FFFF; req0_b = 32'd0;
      req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_b = 32'd8;
      #1;
      check("bp_rdy0_busy", 32'(rr_req0_ready), 32'd0);
      check("bp_rdy1_busy", 32'(rr_req1_ready), 32'd0);
    end
    for (int s = 0; s < 5; s++) begin
      check("bp_valid", 32'(rr_resp_valid), 32'd1);
      check("bp_res", rr_resp_result, 32'h0F0F_0F0F);
      check("bp_id", 32'(rr_resp_id), 32'd0);
      check("bp_rdy0", 32'(rr_req0_ready), 32'd0);
      check("bp_rdy1", 32'(rr_req1_ready), 32'd0);
      @(negedge clk);
      #1;
    end
    resp_ready = 1'b1;
    #1;
    check("bp_drain_valid", 32'(rr_resp_valid), 32'd1);
    check("bp_drain_rdy0", 32'(rr_req0_ready), 32'd0);
    check("bp_drain_rdy1", 32'(rr_req1_ready), 32'd0);
    @(negedge clk);
    #1;
    check("bp_next_rdy1", 32'(rr_req1_ready), 32'd1);
    check("bp_next_rdy0", 32'(rr_req0_ready), 32'd0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      check("bp_next_lat", 32'(rr_resp_valid), 32'(k == LAT));
    end
    check("bp_next_id", 32'(rr_resp_id), 32'd1);
    check("bp_next_res", rr_resp_result, 32'h0012_3456);

    // Fixed priority: req0 wins every tie
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h8000_0000; req0_b = 32'h1F;
    req1_valid = 1'b1; req1_a = 32'h4000_0000; req1_b = 32'd2;
    resp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 3; c++) begin
      #1;
      check("fx_rdy1", 32'(fx_req1_ready), 32'd0);
      if (fx_resp_valid) begin
        check("fx_id", 32'(fx_resp_id), 32'd0);
        check("fx_res", fx_resp_result, 32'h0000_0001);
        got++;
      end
      @(negedge clk);
    end
    check("fx_count", 32'(got), 32'd3);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Asynchronous reset during EXEC
    @(negedge clk);
    resp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hFFFF_0000; req1_b = 32'd16;
    #1;
    check("ra_rdy", 32'(rr_req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("ra_valid", 32'(rr_resp_valid), 32'd0);
    check("ra_id", 32'(rr_resp_id), 32'd0);
    check("ra_res", rr_resp_result, 32'd0);
    check("ra_rdy_rst", 32'(rr_req0_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("ra_stale", 32'(rr_resp_valid), 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset during RESP
    req0_valid = 1'b1; req0_a = 32'hAAAA_AAAA; req0_b = 32'd1;
    #1;
    check("rb_rdy", 32'(rr_req0_ready), 32'd1);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
    end
    #1;
    check("rb_valid_pre", 32'(rr_resp_valid), 32'd1);
    check("rb_res_pre", rr_resp_result, 32'h5555_5555);
    #2;
    rst_n = 1'b0;
    #1;
    check("rb_valid", 32'(rr_resp_valid), 32'd0);
    check("rb_res", rr_resp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("rb_stale", 32'(rr_resp_valid), 32'd0);
      @(negedge clk);
    end

    // First tie after reset goes to req0
    req0_valid = 1'b1; req0_a = 32'h0000_0100; req0_b = 32'd8;
    req1_valid = 1'b1; req1_a = 32'h0000_0001; req1_b = 32'd0;
    resp_ready = 1'b1;
    #1;
    check("rb_tie_rdy0", 32'(rr_req0_ready), 32'd1);
    check("rb_tie_rdy1", 32'(rr_req1_ready), 32'd0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    #1;
    check("rb_tie_valid", 32'(rr_resp_valid), 32'd1);
    check("rb_tie_id", 32'(rr_resp_id), 32'd0);
    check("rb_tie_res", rr_resp_result, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
